// File: rtl/stats_uart_reporter_if.sv
// rtl/stats_uart_reporter_if.sv - stat snapshot request and UART status bundle for the reporter
interface stats_uart_reporter_if;
  logic       report_req;
  logic [4:0] hunger;
  logic [4:0] happiness;
  logic [4:0] hygiene;
  logic [4:0] energy;
  logic [4:0] social;
  logic       is_sleeping;
  logic       uart_tx;
  logic       busy;
  logic       done;
  logic [7:0] drop_count;

  modport master (
    output report_req, hunger, happiness, hygiene, energy, social, is_sleeping,
    input  uart_tx, busy, done, drop_count
  );

  modport slave (
    input  report_req, hunger, happiness, hygiene, energy, social, is_sleeping,
    output uart_tx, busy, done, drop_count
  );
endinterface

// File: rtl/stats_uart_reporter.sv
// rtl/stats_uart_reporter.sv - snapshots pet stats on request and sends them as an 8-byte 8N1 UART packet
module stats_uart_reporter #(
  parameter int CLKS_PER_BIT = 87
) (
  input logic              clk,
  input logic              rst_n,
  stats_uart_reporter_if.slave bus
);

  localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [7:0]    HEADER    = 8'hA5;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    byte_idx;
  logic [7:0]    shift;
  logic [4:0]    snap_hunger;
  logic [4:0]    snap_happiness;
  logic [4:0]    snap_hygiene;
  logic [4:0]    snap_energy;
  logic [4:0]    snap_social;
  logic          snap_sleep;
  logic          tx_r;
  logic          busy_r;
  logic          done_r;
  logic [7:0]    drop_r;
  logic [7:0]    checksum;
  logic [7:0]    cur_byte;
  logic          baud_wrap;

  assign baud_wrap = (baud_cnt == BAUD_LAST);

  always_comb begin
    checksum = {3'b000, snap_hunger ^ snap_happiness ^ snap_hygiene ^ snap_energy ^ snap_social}
             ^ {7'b0, snap_sleep};
    cur_byte = HEADER;
    case (byte_idx)
      3'd0:    cur_byte = HEADER;
      3'd1:    cur_byte = {3'b000, snap_hunger};
      3'd2:    cur_byte = {3'b000, snap_happiness};
      3'd3:    cur_byte = {3'b000, snap_hygiene};
      3'd4:    cur_byte = {3'b000, snap_energy};
      3'd5:    cur_byte = {3'b000, snap_social};
      3'd6:    cur_byte = {7'b0, snap_sleep};
      default: cur_byte = checksum;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      baud_cnt       <= '0;
      bit_idx        <= '0;
      byte_idx       <= '0;
      shift          <= '0;
      snap_hunger    <= '0;
      snap_happiness <= '0;
      snap_hygiene   <= '0;
      snap_energy    <= '0;
      snap_social    <= '0;
      snap_sleep     <= 1'b0;
      tx_r           <= 1'b1;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      drop_r         <= '0;
    end else begin
      done_r <= 1'b0;

      // The done cycle is still part of the packet as far as new requests go.
      if (bus.report_req && (state != IDLE || done_r) && drop_r != 8'hFF)
        drop_r <= drop_r + 8'd1;

      case (state)
        IDLE: begin
          tx_r <= 1'b1;
          if (bus.report_req && !done_r) begin
            snap_hunger    <= bus.hunger;
            snap_happiness <= bus.happiness;
            snap_hygiene   <= bus.hygiene;
            snap_energy    <= bus.energy;
            snap_social    <= bus.social;
            snap_sleep     <= bus.is_sleeping;
            byte_idx       <= '0;
            baud_cnt       <= '0;
            tx_r           <= 1'b0;
            busy_r         <= 1'b1;
            state          <= START;
          end
        end

        START: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= cur_byte;
            tx_r     <= cur_byte[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        DATA: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx_r  <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx_r    <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        STOP: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (byte_idx == 3'd7) begin
              byte_idx <= '0;
              busy_r   <= 1'b0;
              done_r   <= 1'b1;
              state    <= IDLE;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              tx_r     <= 1'b0;
              state    <= START;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.uart_tx    = tx_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.drop_count = drop_r;

endmodule
